clk_freq_meter: RTL

//  Measures an externally generated clock (e.g. pll_out) against sys_clk by counting its rising edges over a fixed gate window.

---
 rtl/clk_freq_meter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/clk_freq_meter.sv
// Frequency meter: counts synchronised rising edges of meas_clk over a fixed sys_clk gate
// window, checks the result against expected_cnt +/- tol_cnt and qualifies a lock flag.
module clk_freq_meter #(
  parameter int unsigned GATE_CYCLES  = 100000,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned LOCK_WINDOWS = 4
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             meas_clk,
  input  logic             enable,
  input  logic [CNT_W-1:0] expected_cnt,
  input  logic [CNT_W-1:0] tol_cnt,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             in_range,
  output logic             overflow,
  output logic             locked,
  output logic             busy
);

  localparam int unsigned TMR_W = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam int unsigned STK_W = $clog2(LOCK_WINDOWS + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(LOCK_WINDOWS);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_GATE,
    ST_REPORT
  } state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_range_q, in_range_d;
  logic             overflow_q, overflow_d;
  logic [STK_W-1:0] streak_q, streak_d;
  logic             locked_q, locked_d;

  logic             meas_edge;
  logic [CNT_W-1:0] cnt_gate;
  logic             sat_gate;
  logic [CNT_W-1:0] abs_diff;
  logic             win_in_range;
  logic [STK_W-1:0] streak_win;

  // The synchroniser runs in every state so ARM never sees a stale history bit.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= meas_clk;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign meas_edge = s2_q & ~s3_q;

  // Counter value including this cycle's edge; it sticks at all-ones, so "at max" is the sat flag.
  assign cnt_gate     = (meas_edge && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;
  assign sat_gate     = (cnt_gate == CNT_MAX);
  assign abs_diff     = (cnt_gate >= expected_cnt) ? cnt_gate - expected_cnt
                                                   : expected_cnt - cnt_gate;
  assign win_in_range = !sat_gate && (abs_diff <= tol_cnt);
  assign streak_win   = !win_in_range        ? '0 :
                        (streak_q == STK_MAX) ? streak_q : streak_q + STK_W'(1);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    cnt_d      = cnt_q;
    count_d    = count_q;
    in_range_d = in_range_q;
    overflow_d = overflow_q;
    streak_d   = streak_q;
    locked_d   = locked_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_ARM;
      end
      ST_ARM, ST_GATE: begin
        if (!enable) begin
          state_d  = ST_IDLE;
          streak_d = '0;
          locked_d = 1'b0;
        end else if (state_q == ST_ARM) begin
          timer_d = '0;
          cnt_d   = '0;
          state_d = ST_GATE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
          cnt_d   = cnt_gate;
          // Results load on entry to REPORT so they are already visible while count_valid is high.
          if (timer_q == TMR_LAST) begin
            state_d    = ST_REPORT;
            count_d    = cnt_gate;
            overflow_d = sat_gate;
            in_range_d = win_in_range;
            streak_d   = streak_win;
            locked_d   = (streak_win == STK_MAX);
          end
        end
      end
      ST_REPORT: begin
        state_d = enable ? ST_ARM : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      cnt_q      <= '0;
      count_q    <= '0;
      in_range_q <= 1'b0;
      overflow_q <= 1'b0;
      streak_q   <= '0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      cnt_q      <= cnt_d;
      count_q    <= count_d;
      in_range_q <= in_range_d;
      overflow_q <= overflow_d;
      streak_q   <= streak_d;
      locked_q   <= locked_d;
    end
  end

  assign count       = count_q;
  assign in_range    = in_range_q;
  assign overflow    = overflow_q;
  assign locked      = locked_q;
  assign count_valid = (state_q == ST_REPORT);
  assign busy        = (state_q == ST_ARM) || (state_q == ST_GATE);

endmodule
